// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot sequencer.
// Optional feature macro: BOOT_CHECKSUM_EN (adds the S_CHK checksum state).
package boot_pkg;

  localparam int LEN_BYTES      = 2;  // length prefix is a 16-bit little-endian word count
  localparam int BYTES_PER_WORD = 4;  // instruction words are packed little-endian

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_RUN,
    S_ERR
  } boot_state_t;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Byte-stream input and instruction-memory write port of the boot sequencer.
// The slave modport is the sequencer; the master modport is the host/memory side.
interface imem_boot_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_ctrl_word_packer.sv
// Collects stream bytes into little-endian 32-bit words.
// word is the completed word when word_done pulses (the byte arriving in lane 3
// is combined directly with the three stored bytes).
module word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);
  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       shift_q, shift_d;

  // Newest byte enters at the top, so after four bytes the first one sits in [7:0].
  assign word      = {byte_in, shift_q[31:8]};
  assign word_done = byte_en && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

  // Next lane and shift contents; clear wins over a byte.
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clr) begin
      lane_d  = '0;
      shift_d = '0;
    end else if (byte_en) begin
      lane_d  = lane_q + LANE_W'(1);
      shift_d = word;
    end
  end

  // Lane counter and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end
endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: loads a length-prefixed byte stream into instruction memory
// and then releases the CPU from reset. start restarts loading at any time.
// Optional feature macro: BOOT_CHECKSUM_EN (trailing XOR checksum byte).
module imem_boot_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_boot_ctrl_if.slave bus,
  output logic            cpu_reset,
  output logic            busy,
  output logic            err
);
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t S_DONE = S_CHK;
`else
  localparam boot_state_t S_DONE = S_RUN;
`endif

  boot_state_t       state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   n_q, n_d;      // one extra bit so a full memory does not alias to 0
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic        rx_ready_w;
  logic        accept;
  logic        pk_en;
  logic        pk_clr;
  logic [31:0] pk_word;
  logic        pk_done;
  logic [16:0] n_full;

  assign accept = bus.rx_valid && rx_ready_w;
  assign n_full = {1'b0, bus.rx_data, len_lo_q};
  assign pk_en  = accept && !start && (state_q == S_DATA);
  assign pk_clr = start || (accept && (state_q == S_LEN_HI));

  word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (pk_clr),
    .byte_en   (pk_en),
    .byte_in   (bus.rx_data),
    .word      (pk_word),
    .word_done (pk_done)
  );

  // Ready decode; S_DATA pauses for the cycle the final write is on the bus.
  always_comb begin
    rx_ready_w = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI: rx_ready_w = 1'b1;
      S_DATA:             rx_ready_w = (idx_q != n_q);
`ifdef BOOT_CHECKSUM_EN
      S_CHK:              rx_ready_w = 1'b1;
`endif
      default:            rx_ready_w = 1'b0;
    endcase
  end

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;

  // Running XOR over data bytes, restarted for every new stream.
  always_comb begin
    xor_d = xor_q;
    if (pk_clr)     xor_d = '0;
    else if (pk_en) xor_d = xor_q ^ bus.rx_data;
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (reset) xor_q <= '0;
    else       xor_q <= xor_d;
  end
`endif

  // Next-state, counters and registered output values.
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    n_d      = n_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (start) begin
      state_d  = S_LEN_LO;
      len_lo_d = '0;
      n_d      = '0;
      idx_d    = '0;
    end else begin
      case (state_q)
        S_LEN_LO: if (accept) begin
          len_lo_d = bus.rx_data;
          state_d  = S_LEN_HI;
        end
        S_LEN_HI: if (accept) begin
          idx_d = '0;
          if (n_full == 17'd0) begin
            state_d = S_DONE;
          end else if (n_full > CAP) begin
            state_d = S_ERR;
          end else begin
            n_d     = n_full[ADDR_W:0];
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (idx_q == n_q) begin
            // Last word is being written this cycle; leave on the next edge.
            state_d = S_DONE;
          end else if (pk_done) begin
            we_d    = 1'b1;
            addr_d  = idx_q[ADDR_W-1:0];
            wdata_d = pk_word;
            idx_d   = idx_q + 1'b1;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CHK: if (accept) begin
          state_d = (bus.rx_data == xor_q) ? S_RUN : S_ERR;
        end
`endif
        default: ;
      endcase
    end
    cpu_reset_d = (state_d != S_RUN);
    busy_d      = (state_d == S_LEN_HI) || (state_d == S_DATA)
`ifdef BOOT_CHECKSUM_EN
                  || (state_d == S_CHK)
`endif
                  ;
    err_d       = (state_d == S_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LEN_LO;
      len_lo_q    <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.rx_ready   = rx_ready_w;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign busy           = busy_q;
  assign err            = err_q;
endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot sequencer that owns the instruction memory and reset line of the single-cycle RISC-V CPU. It accepts a length-prefixed byte stream from a host link, such as a UART receiver. It packs the bytes into little-endian 32-bit words, writes them to consecutive instruction-memory word addresses, and only then releases the CPU from reset. A `start` pulse re-enters load mode at any time, with the CPU held in reset.

## Interface
Parameters:
- `ADDR_W`, default 10: instruction-memory word-address width. Capacity is 2^ADDR_W words.

Ports:
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: synchronous, active-high.
- `start` input, 1 bit: single-cycle pulse that aborts the current load or run and restarts loading.
- `rx_valid` input, 1 bit: a byte is present on `rx_data`.
- `rx_data` input, 8 bits: stream byte.
- `rx_ready` output, 1 bit: the block accepts a byte this cycle.
- `imem_we` output, 1 bit: instruction-memory write strobe.
- `imem_addr` output, ADDR_W bits: word address.
- `imem_wdata` output, 32 bits: word to write.
- `cpu_reset` output, 1 bit: drives the CPU `reset` input.
- `busy` output, 1 bit: a load is in progress.
- `err` output, 1 bit: the load failed; sticky until `start` or `reset`.

## Operation
- A byte is accepted on any cycle where `rx_valid && rx_ready`. All other bytes are ignored; the block never drops an accepted byte.
- Stream format: `LEN_LO`, `LEN_HI` (16-bit word count N, little-endian), then 4·N data bytes, least-significant byte first.
- FSM states: S_LEN_LO, S_LEN_HI, S_DATA, S_CHK (only with the macro), S_RUN, S_ERR.
- S_LEN_LO:
  - `rx_ready`=1.
  - On accept, latch the low byte and go to S_LEN_HI.
- S_LEN_HI:
  - `rx_ready`=1.
  - On accept, form N.
  - N=0 → S_RUN, with no writes.
  - N > 2^ADDR_W → S_ERR.
  - Otherwise → S_DATA, with word index 0 and byte lane 0.
- S_DATA:
  - `rx_ready`=1.
  - Each accepted byte goes into lane 0..3, and the lane counter increments (2-bit, wraps).
  - On lane 3 accept, register a write: the next cycle has `imem_we`=1, `imem_addr`=index, `imem_wdata`=packed word. The index then increments.
  - After the write of word N−1: → S_RUN, or → S_CHK with the macro.
  - The index is ADDR_W+1 bits wide internally, so N = 2^ADDR_W does not alias.
- S_RUN:
  - `rx_ready`=0, `cpu_reset`=0.
  - Further stream bytes are not consumed.
- S_ERR:
  - `rx_ready`=0, `cpu_reset`=1, `err`=1.
- `start` in any state: next state is S_LEN_LO; counters, `err` and lane are cleared, and `cpu_reset`=1. `start` has priority over a simultaneous byte accept, and that byte is discarded.
- `cpu_reset`=1 in every state except S_RUN.
- `busy`=1 in S_LEN_HI, S_DATA and S_CHK.

## Timing
- Reset values:
  - state S_LEN_LO
  - `rx_ready`=1
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0
  - `cpu_reset`=1
  - `busy`=0
  - `err`=0
- All outputs are registered, except `rx_ready`, which is decoded from state.
- Write latency: `imem_we` is high exactly one cycle, the cycle after the lane-3 accept. Back-to-back bytes sustain one word per 4 cycles.
- After the final word:
  - Cycle t: `imem_we`=1 for word N−1.
  - Cycle t+1: `cpu_reset`=0.
  - The CPU therefore never fetches during a write.
- With N=0, `cpu_reset` falls on the cycle after the `LEN_HI` accept.
- `start` in cycle t: `cpu_reset`=1 and `rx_ready`=1 from cycle t+1.
- `reset` mid-load: returns to the reset values with no partial `imem_we`. Words already written remain in memory.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - A running 8-bit XOR is kept over all data bytes. It is cleared on entry to S_DATA.
  - After word N−1 is written, S_CHK accepts one checksum byte.
  - Match → S_RUN next cycle. Mismatch → S_ERR.
  - For N=0, S_CHK expects 0x00.
- `BOOT_CHECKSUM_EN` undefined:
  - There is no S_CHK state and no XOR register.
  - The stream ends at the last data byte.
  - `err` is raised only by length overflow.

## Structure
- Package `boot_pkg`: state enum, `LEN_BYTES`=2, `BYTES_PER_WORD`=4.
- One sub-module, `word_packer`: byte lane counter, 32-bit shift/pack register, and a `word_done` pulse.
- The FSM, index counter and checksum live in the top level.

## Test plan
- Reset, then stream 02 00 | 13 00 50 00 | 93 00 10 00 → `imem_we` twice: addr 0 = 0x00500013, addr 1 = 0x00100093. `cpu_reset` falls the cycle after the second write.
- Stream 00 00 → no `imem_we`; `cpu_reset`=0 one cycle after the `LEN_HI` accept.
- With ADDR_W=4, stream 11 00 (N=17) → `err`=1, `rx_ready`=0, `cpu_reset` stays 1. Then `start` → `err`=0 and `rx_ready`=1 next cycle.
- Random `rx_valid` gaps within a 3-word load → same addresses and data as the gap-free load; `imem_we` fires only on word completion.
- `start` asserted after 2 data bytes, in the same cycle as a third accept → that byte is discarded. A fresh stream 01 00 | EF BE AD DE then writes addr 0 = 0xDEADBEEF.
- With `BOOT_CHECKSUM_EN`, stream 01 00 | 01 02 04 08 | 0F → S_RUN. A trailing 0E instead → `err`=1 and `cpu_reset` stays 1.
